// File: rtl/hdma_disp_timing_pkg.sv
// Shared HDMA display-timing definitions: controller states and 720p defaults.
package hdma_disp_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } disp_state_e;

  // 1280x720 @ 60 Hz horizontal timing, in pixels
  localparam int DEF_H_SYNC  = 40;
  localparam int DEF_H_BACK  = 220;
  localparam int DEF_H_DISP  = 1280;
  localparam int DEF_H_FRONT = 110;

  // 1280x720 @ 60 Hz vertical timing, in lines
  localparam int DEF_V_SYNC  = 5;
  localparam int DEF_V_BACK  = 20;
  localparam int DEF_V_DISP  = 720;
  localparam int DEF_V_FRONT = 5;

endpackage

// File: rtl/hdma_disp_timing.sv
// Display timing generator: raster counters, FIFO read requests and a
// 3-cycle aligned sync/enable/data pipeline. Frames always finish in full.
module hdma_disp_timing
  import hdma_disp_timing_pkg::*;
#(
  parameter int VIDEO_DATA_BIT = 32,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int H_DISP  = DEF_H_DISP,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter int V_DISP  = DEF_V_DISP,
  parameter int V_FRONT = DEF_V_FRONT
) (
  input  logic                      rd_clk,
  input  logic                      rst_n,
  input  logic                      disp_en,
  input  logic [VIDEO_DATA_BIT-1:0] pic_data,
  output logic                      rdata_req,
  output logic                      rd_load,
  output logic [12:0]               h_disp,
  output logic                      vid_hs,
  output logic                      vid_vs,
  output logic                      vid_de,
  output logic [VIDEO_DATA_BIT-1:0] vid_data
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [12:0] H_LAST  = 13'(H_TOTAL - 1);
  localparam logic [12:0] H_SYNCE = 13'(H_SYNC);
  localparam logic [12:0] H_ACT_S = 13'(H_SYNC + H_BACK);
  localparam logic [12:0] H_ACT_E = 13'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_SYNCE = 11'(V_SYNC);
  localparam logic [10:0] V_ACT_S = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_ACT_E = 11'(V_SYNC + V_BACK + V_DISP - 1);

  disp_state_e state_q, state_d;
  logic [12:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;

  logic counting, frame_last;
  logic hs_raw, vs_raw, act_raw;

  logic                      rdata_req_q, rd_load_q;
  logic                      de_p0, vid_de_q;
  logic                      hs_p0, hs_p1, vid_hs_q;
  logic                      vs_p0, vs_p1, vid_vs_q;
  logic [VIDEO_DATA_BIT-1:0] vid_data_q;

  assign counting   = (state_q != ST_IDLE);
  assign frame_last = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

  assign hs_raw  = counting && (h_cnt_q < H_SYNCE);
  assign vs_raw  = counting && (v_cnt_q < V_SYNCE);
  assign act_raw = counting &&
                   (h_cnt_q >= H_ACT_S) && (h_cnt_q <= H_ACT_E) &&
                   (v_cnt_q >= V_ACT_S) && (v_cnt_q <= V_ACT_E);

  // Next state and raster counter advance; counters park at 0 while idle
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      ST_IDLE: if (disp_en) state_d = ST_RUN;
      ST_RUN:  if (!disp_en) state_d = ST_STOP;
      ST_STOP: begin
        if (disp_en)         state_d = ST_RUN;
        else if (frame_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!counting) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    end else begin
      h_cnt_d = h_cnt_q + 13'd1;
    end
  end

  // State and counter registers; reset aborts any frame in progress
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Output pipeline: req one cycle after counters, sync/de three cycles,
  // data captured the cycle FIFO read data returns
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      rdata_req_q <= 1'b0;
      rd_load_q   <= 1'b1;
      de_p0       <= 1'b0;
      vid_de_q    <= 1'b0;
      hs_p0       <= 1'b0;
      hs_p1       <= 1'b0;
      vid_hs_q    <= 1'b0;
      vs_p0       <= 1'b0;
      vs_p1       <= 1'b0;
      vid_vs_q    <= 1'b0;
      vid_data_q  <= '0;
    end else begin
      // stage p0: counters -> request / load
      rdata_req_q <= act_raw;
      rd_load_q   <= counting ? vs_raw : 1'b1;
      hs_p0       <= hs_raw;
      vs_p0       <= vs_raw;
      // stage p1: request -> enable pipe
      de_p0       <= rdata_req_q;
      hs_p1       <= hs_p0;
      vs_p1       <= vs_p0;
      // stage p2: aligned outputs
      vid_de_q    <= de_p0;
      vid_hs_q    <= hs_p1;
      vid_vs_q    <= vs_p1;
      vid_data_q  <= de_p0 ? pic_data : '0;
    end
  end

  assign rdata_req = rdata_req_q;
  assign rd_load   = rd_load_q;
  assign h_disp    = 13'(H_DISP);
  assign vid_hs    = vid_hs_q;
  assign vid_vs    = vid_vs_q;
  assign vid_de    = vid_de_q;
  assign vid_data  = vid_data_q;

endmodule

// File: tb/tb_hdma_disp_timing.sv
// Bench for hdma_disp_timing with a small 15x7 raster. Expected outputs per
// cycle are derived from the raster position since frame start and queued;
// a monitor compares them against the DUT outputs.
module tb_hdma_disp_timing;

  localparam int W  = 32;
  localparam int HT = 15;
  localparam int VT = 7;
  localparam int FR = HT * VT;
  localparam longint BIG = 64'd1 << 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          disp_en = 1'b0;
  logic [W-1:0]  pic_data = '0;
  logic          rdata_req, rd_load, vid_hs, vid_vs, vid_de;
  logic [12:0]   h_disp;
  logic [W-1:0]  vid_data;

  hdma_disp_timing #(
    .VIDEO_DATA_BIT(W),
    .H_SYNC(2), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_DISP(4), .V_FRONT(1)
  ) dut (
    .rd_clk(clk), .rst_n(rst_n), .disp_en(disp_en), .pic_data(pic_data),
    .rdata_req(rdata_req), .rd_load(rd_load), .h_disp(h_disp),
    .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de), .vid_data(vid_data)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic         req, load, hs, vs, de;
    logic [W-1:0] data;
    longint       n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // model state: reset edge, run start edge, run length in cycles
  longint rs = 0;
  longint e0 = BIG;
  longint end_k = BIG;

  function automatic bit run_at(longint m);
    return (m > rs) && (m >= e0) && ((m - e0) < end_k);
  endfunction
  function automatic int hpos(longint m);
    return int'(((m - e0) % FR) % HT);
  endfunction
  function automatic int vpos(longint m);
    return int'(((m - e0) % FR) / HT);
  endfunction
  function automatic bit act_at(longint m);
    return run_at(m) && hpos(m) >= 5 && hpos(m) <= 12 && vpos(m) >= 2 && vpos(m) <= 5;
  endfunction
  function automatic bit hs_at(longint m);
    return run_at(m) && hpos(m) < 2;
  endfunction
  function automatic bit vs_at(longint m);
    return run_at(m) && vpos(m) < 1;
  endfunction

  function automatic exp_t exp_at(longint n);
    exp_t e;
    e.req  = act_at(n - 1);
    e.de   = act_at(n - 3);
    e.hs   = hs_at(n - 3);
    e.vs   = vs_at(n - 3);
    e.load = run_at(n - 1) ? vs_at(n - 1) : 1'b1;
    e.data = e.de ? W'(hpos(n - 3) - 5) : '0;
    e.n    = n;
    return e;
  endfunction

  // Called at a falling edge: queue the expectation for the next rising edge
  task automatic adv(input int c);
    repeat (c) begin
      q.push_back(exp_at(cyc + 1));
      @(negedge clk);
    end
  endtask

  // Advance until the counters after the next edge sit at (v,h)
  task automatic adv_to(input int v, input int h);
    for (int i = 0; i < FR && (((cyc + 1 - e0) % FR) != longint'(v * HT + h)); i++)
      adv(1);
  endtask

  task automatic do_reset(input int c);
    rst_n = 1'b0;
    rs = cyc + 1;
    e0 = BIG;
    end_k = BIG;
    adv(c);
  endtask

  task automatic start_run();
    rst_n = 1'b1;
    disp_en = 1'b1;
    e0 = cyc + 1;
    end_k = BIG;
  endtask

  task automatic drop_en();
    longint k;
    disp_en = 1'b0;
    k = cyc + 1 - e0;
    end_k = FR * (k / FR + 1);
  endtask

  task automatic reenable();
    disp_en = 1'b1;
    end_k = BIG;
  endtask

  // FIFO model: returns the next pixel of the line one cycle after each request
  logic   req_prev = 1'b0;
  int     pix = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) pix = 0;
      if (req_prev) begin
        pic_data = W'(pix);
        pix = (pix == 7) ? 0 : pix + 1;
      end else begin
        pic_data = 32'hDEAD_BEEF;
      end
      req_prev = rdata_req;
    end
  end

  // Monitor: pop the expectation for this edge and compare all outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].n < cyc) begin
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL sb_skew cyc=%0d stale expectation for edge %0d", cyc, e.n);
      end
      if (q.size() > 0 && q[0].n == cyc) begin
        e = q.pop_front();
        total++;
        if ({rdata_req, rd_load, vid_hs, vid_vs, vid_de, vid_data, h_disp} !==
            {e.req, e.load, e.hs, e.vs, e.de, e.data, 13'd8}) begin
          bad++;
          $display("FAIL outputs cyc=%0d got req=%b load=%b hs=%b vs=%b de=%b data=%h hdisp=%0d want req=%b load=%b hs=%b vs=%b de=%b data=%h hdisp=8",
                   cyc, rdata_req, rd_load, vid_hs, vid_vs, vid_de, vid_data, h_disp,
                   e.req, e.load, e.hs, e.vs, e.de, e.data);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // reset values, then release straight into a run
    do_reset(5);
    start_run();
    adv(3 * FR);
    // reset in the middle of an active line, then restart from zero
    adv_to(3, 8);
    do_reset(3);
    start_run();
    adv(FR + 20);
    // disable on line 3: frame finishes, then idle
    adv_to(3, 0);
    drop_en();
    adv(FR + 12);
    // restart from idle; stop and re-enable mid-frame, then stop again
    start_run();
    adv(FR);
    adv_to(2, 3);
    drop_en();
    adv(20);
    adv_to(4, 6);
    reenable();
    adv(FR + 10);
    adv_to(1, 0);
    drop_en();
    adv(FR + 12);
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain leftover=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
